axi_multi_channel_streamer: RTL
===============================

Name: axi_multi_channel_streamer

Overview:
Parametrised successor to the fixed five-channel AXI-to-stream monitor. It snoops NUM_CH generic valid/ready channels, such as the AR/AW/R/W/B channels of an AXI port. Each completed handshake's payload is captured into a per-channel FIFO. A round-robin arbiter serialises the captured records onto one AXI4-Stream master, tagged with the channel index in tuser, and split into multiple beats when the payload is wider than the stream. The block sits passively between the AXI fabric and the Ethernet/stream path and never back-pressures the monitored channels.

Parameters:
NUM_CH, 5, number of monitored channels (1..16)
CH_DATA_W, 64, payload width captured per channel
TDATA_W, 64, output stream data width
FIFO_DEPTH, 4, entries per channel FIFO (power of two, >=2)
CNT_W, 16, width of each per-channel drop counter
(derived) CH_ID_W = max(1, clog2(NUM_CH)); BEATS = ceil(CH_DATA_W/TDATA_W)

Ports:
aclk  in  1  single clock, all logic on rising edge
areset  in  1  synchronous, active-high reset
mon_valid  in  NUM_CH  snooped valid, one bit per channel
mon_ready  in  NUM_CH  snooped ready, one bit per channel
mon_data  in  NUM_CH*CH_DATA_W  snooped payloads; channel i occupies bits [i*CH_DATA_W +: CH_DATA_W]
ch_en  in  NUM_CH  per-channel capture enable
m_axis_tdata  out  TDATA_W  stream data
m_axis_tvalid  out  1  stream valid
m_axis_tready  in  1  stream ready
m_axis_tlast  out  1  high on the last beat of each record
m_axis_tuser  out  CH_ID_W  channel index of the current record
fifo_full  out  NUM_CH  per-channel FIFO full flag
drop_cnt  out  NUM_CH*CNT_W  per-channel saturating drop counters

Behaviour:
- Reset (areset=1 at a clock edge) does all of the following:
  - empties all FIFOs and zeroes all drop counters;
  - drives tvalid=0, tlast=0, tdata=0, tuser=0;
  - puts the FSM in IDLE and sets the rr pointer to NUM_CH-1, so channel 0 has first priority.
- Reset mid-record discards the partial record; no tlast is emitted for it.
- Capture rules:
  - Channel i is captured at edge N when mon_valid[i] & mon_ready[i] & ch_en[i].
  - A channel with valid high but ready low is not captured.
  - A capture is accepted if the FIFO is not full, or if the FIFO is popped in the same cycle.
  - Otherwise the capture is dropped and drop_cnt[i] increments, saturating at all-ones.
  - ch_en[i]=0 blocks new captures and never counts drops. Entries already queued still drain.
- fifo_full[i] is registered and reflects occupancy == FIFO_DEPTH after each edge.
- FSM has two states, IDLE and SEND.
  - IDLE: if any FIFO is non-empty, grant the first non-empty channel searching from rr+1 with wrap-around. Then:
    - pop its head into the output shift register;
    - set rr = granted channel, beat_cnt = 0, tuser = granted channel;
    - assert tvalid; set tlast = (BEATS==1);
    - go to SEND.
    - If all FIFOs are empty, stay in IDLE.
  - SEND: on tvalid & tready:
    - if beat_cnt == BEATS-1, deassert tvalid and tlast and return to IDLE;
    - otherwise shift in the next TDATA_W slice, increment beat_cnt, and set tlast = (beat_cnt+1 == BEATS-1).
- Beat order: beat 0 carries payload bits [TDATA_W-1:0], ascending. The final beat is zero-padded above CH_DATA_W.
- While tvalid=1 and tready=0, tdata, tlast and tuser hold stable (AXI4-Stream rule).
- Latency and throughput:
  - A capture at edge N produces tvalid=1 after edge N+1 if the FSM was in IDLE.
  - There is exactly one idle cycle between consecutive records. Sustained rate is BEATS/(BEATS+1) beats per cycle.
- Arbitration is locked for the duration of a record. Channels never interleave within a record.

Test Plan:
1. Defaults; one handshake on ch2 with data 0xDEADBEEF00000002, tready=1 -> one beat with tdata=0xDEADBEEF00000002, tuser=2, tlast=1; tvalid rises one edge after the capture edge.
2. Handshakes on all 5 channels in the same cycle (data = channel index), tready=1 -> records in tuser order 0,1,2,3,4, each separated by one idle cycle; drop_cnt all 0.
3. CH_DATA_W=96, TDATA_W=32, ch0 data 0x333333332222222211111111, tready toggling 5 low / 5 high -> beats 0x11111111, 0x22222222, 0x33333333 in that order, tlast only on the third, data held stable while tready=0.
4. FIFO_DEPTH=4, tready=0, 6 handshakes on ch1 (the first is popped into the output register) -> after 6 captures fifo_full[1]=1 and drop_cnt[1]=1; release tready -> exactly 5 records with tuser=1 appear.
5. ch_en[3]=0 with 3 handshakes on ch3 -> no output and drop_cnt[3]=0. Then ch0 and ch4 both captured every cycle -> grants alternate 0,4,0,4.
6. areset pulsed during beat 1 of a 3-beat record -> tvalid=0 after that edge, no tlast emitted, all fifo_full and drop_cnt read 0.

Source files
------------

// File: rtl/axi_multi_channel_streamer.sv
// axi_multi_channel_streamer: passively snoops NUM_CH valid/ready channels, queues
// each completed handshake per channel, and serialises the queued records onto one
// AXI4-Stream master (round-robin, channel index in tuser, multi-beat when wide).

// Per-channel capture FIFO with registered full flag and saturating drop counter.
module axi_multi_channel_streamer_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             capture,
  input  logic             pop,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     head,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] drop_cnt
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count, count_nxt;
  logic          push, drop;

  // A full FIFO still accepts a capture when its head leaves in the same cycle.
  assign push  = capture & (~full | pop);
  assign drop  = capture & full & ~pop;
  assign empty = (count == '0);
  assign head  = mem[rptr];

  // Occupancy after this edge; full is registered from it.
  always_comb count_nxt = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

  // Payload storage needs no reset; only pointers and count define validity.
  always_ff @(posedge aclk) begin
    if (push) mem[wptr] <= din;
  end

  // Pointers, occupancy, full flag and drop counter.
  always_ff @(posedge aclk) begin
    if (areset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      full     <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == (AW+1)'(DEPTH));
      if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
    end
  end
endmodule

module axi_multi_channel_streamer #(
  parameter  int NUM_CH     = 5,
  parameter  int CH_DATA_W  = 64,
  parameter  int TDATA_W    = 64,
  parameter  int FIFO_DEPTH = 4,
  parameter  int CNT_W      = 16,
  localparam int CH_ID_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic [NUM_CH-1:0]         mon_valid,
  input  logic [NUM_CH-1:0]         mon_ready,
  input  logic [NUM_CH*CH_DATA_W-1:0] mon_data,
  input  logic [NUM_CH-1:0]         ch_en,
  output logic [TDATA_W-1:0]        m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      m_axis_tlast,
  output logic [CH_ID_W-1:0]        m_axis_tuser,
  output logic [NUM_CH-1:0]         fifo_full,
  output logic [NUM_CH*CNT_W-1:0]   drop_cnt
);
  localparam int BEATS = (CH_DATA_W + TDATA_W - 1) / TDATA_W;
  localparam int SH_W  = BEATS * TDATA_W;
  localparam int BC_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                            state, state_nxt;
  logic [NUM_CH-1:0][CH_DATA_W-1:0]  heads;
  logic [NUM_CH-1:0]                 empty, capture, pop_vec;
  logic [CH_ID_W-1:0]                rr, gnt_ch;
  logic                              gnt_vld, load, adv, last_beat;
  logic [SH_W-1:0]                   shreg;
  logic [BC_W-1:0]                   beat_cnt;

  assign capture      = mon_valid & mon_ready & ch_en;
  assign last_beat    = (beat_cnt == BC_W'(BEATS-1));
  assign m_axis_tdata = shreg[TDATA_W-1:0];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    axi_multi_channel_streamer_fifo #(
      .W(CH_DATA_W), .DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)
    ) u_fifo (
      .aclk    (aclk),
      .areset  (areset),
      .capture (capture[i]),
      .pop     (pop_vec[i]),
      .din     (mon_data[i*CH_DATA_W +: CH_DATA_W]),
      .head    (heads[i]),
      .empty   (empty[i]),
      .full    (fifo_full[i]),
      .drop_cnt(drop_cnt[i*CNT_W +: CNT_W])
    );
  end

  // Round-robin search: first non-empty channel after the last grant, wrapping.
  always_comb begin
    int idx;
    idx     = 0;
    gnt_vld = 1'b0;
    gnt_ch  = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = int'(rr) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!gnt_vld && !empty[CH_ID_W'(idx)]) begin
        gnt_vld = 1'b1;
        gnt_ch  = CH_ID_W'(idx);
      end
    end
  end

  // State register.
  always_ff @(posedge aclk) begin
    if (areset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: a record locks the arbiter until its last beat is accepted.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_vld) state_nxt = SEND;
      SEND:    if (m_axis_tvalid && m_axis_tready && last_beat) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM controls: load a granted head in IDLE, advance on accepted beats in SEND.
  always_comb begin
    load    = (state == IDLE) && gnt_vld;
    adv     = (state == SEND) && m_axis_tvalid && m_axis_tready;
    pop_vec = '0;
    if (load) pop_vec[gnt_ch] = 1'b1;
  end

  // Output shift register and stream sideband; held while tready is low.
  always_ff @(posedge aclk) begin
    if (areset) begin
      shreg         <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= '0;
      rr            <= CH_ID_W'(NUM_CH-1);
      beat_cnt      <= '0;
    end else if (load) begin
      shreg         <= SH_W'(heads[gnt_ch]);
      rr            <= gnt_ch;
      m_axis_tuser  <= gnt_ch;
      beat_cnt      <= '0;
      m_axis_tvalid <= 1'b1;
      m_axis_tlast  <= (BEATS == 1);
    end else if (adv) begin
      if (last_beat) begin
        m_axis_tvalid <= 1'b0;
        m_axis_tlast  <= 1'b0;
      end else begin
        shreg        <= shreg >> TDATA_W;
        beat_cnt     <= beat_cnt + 1'b1;
        m_axis_tlast <= ((beat_cnt + BC_W'(1)) == BC_W'(BEATS-1));
      end
    end
  end
endmodule
